// File: rtl/apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// apb_regfile_slave
//
// APB slave that holds a register file of NUM_REGS words of DATA_WIDTH bits.
// It supports programmable wait states, byte write strobes and read-only
// registers. It flags decode errors and protocol errors on pslave_error.
//
// Ports
//   pclk          in   clock; every state change happens on the rising edge
//   presetn       in   asynchronous active-low reset
//   paddr         in   byte address (ADDR_WIDTH)
//   pselx         in   slave select
//   penable       in   access-phase indicator
//   pwrite        in   1 = write, 0 = read
//   pwdata        in   write data (DATA_WIDTH)
//   pstrb         in   byte write enables (DATA_WIDTH/8)
//   pready        out  the transfer completes in this cycle
//   prdata        out  read data; zero unless pready is high and no error
//   pslave_error  out  error flag; zero unless pready is high
//
// The outputs are combinational from the internal state and the APB inputs.
// The module has no output registers.
// -----------------------------------------------------------------------------
module apb_regfile_slave #(
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    pselx,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslave_error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);
    // One extra bit so that NUM_REGS == 2^(ADDR_WIDTH-OFFS) is still representable.
    localparam logic [ADDR_WIDTH:0]   NREGS    = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0]            WS       = 4'(WAIT_STATES);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_armed;
    logic [3:0]            r_wcnt;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [IDX_W-1:0]      w_ridx;
    logic                  w_in_range;
    logic                  w_misaligned;
    logic                  w_ro;
    logic                  w_viol;
    logic                  w_access;
    logic                  w_ready;
    logic                  w_err;
    logic                  w_wr_en;

    // Address decode
    assign w_idx        = paddr >> OFFS;
    assign w_ridx       = w_idx[IDX_W-1:0];
    assign w_in_range   = ({1'b0, w_idx} < NREGS);
    assign w_misaligned = ((paddr & LOW_MASK) != '0);
    // Look at the read-only mask only for a decoded index, so that an
    // out-of-range index never selects a mask bit.
    assign w_ro         = w_in_range && RO_MASK[w_ridx];

    // Handshake. An enable with no prior setup is a protocol violation.
    // It completes at once so that the master is not stalled.
    assign w_viol   = pselx & penable & ~r_armed;
    assign w_access = pselx & penable &  r_armed;
    // Gating with presetn keeps pready low while reset is asserted, even if
    // the master leaves pselx and penable high.
    assign w_ready  = presetn & (w_viol | (w_access & (r_wcnt == WS)));

    assign w_err    = w_misaligned | ~w_in_range | (pwrite & w_ro) | w_viol;
    assign w_wr_en  = w_ready & pwrite & ~w_err;

    assign pready       = w_ready;
    assign pslave_error = w_ready & w_err;
    assign prdata       = (w_ready && !w_err) ? r_regs[w_ridx] : '0;

    // Transfer tracking: armed by a setup phase, cleared by completion or abort.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_armed <= 1'b0;
            r_wcnt  <= '0;
        end else if (pselx && !penable) begin
            // A setup phase may directly follow a completion cycle.
            r_armed <= 1'b1;
            r_wcnt  <= '0;
        end else if (w_ready) begin
            r_armed <= 1'b0;
            r_wcnt  <= '0;
        end else if (!pselx) begin
            r_armed <= 1'b0;
            r_wcnt  <= '0;
        end else if (w_access && (r_wcnt < WS)) begin
            r_wcnt  <= r_wcnt + 4'd1;
        end
    end

    // Register file with byte-lane writes on the completion edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_en) begin
            for (int k = 0; k < BYTES; k++) begin
                if (pstrb[k]) begin
                    r_regs[w_ridx][k*8 +: 8] <= pwdata[k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_regfile_slave
//
// Three slave instances with WAIT_STATES of 0, 2 and 3. All three share the
// clock and reset, and each has its own APB bus. A behavioural model holds,
// for each instance, the register contents, the setup state and the number
// of access cycles seen. The model predicts pready, prdata and pslave_error.
// A compare process checks those outputs on every falling edge. Directed
// transfers also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_apb_regfile_slave;

    localparam logic [15:0] RO = 16'h0020;   // register 5 is read-only

    logic        clk     = 1'b0;
    logic        presetn = 1'b1;
    logic [2:0]  psel    = '0;
    logic [2:0]  pen     = '0;
    logic [2:0]  pwr     = '0;
    logic [2:0]  rdy;
    logic [2:0]  perr;
    logic [7:0]  addr [3] = '{default: '0};
    logic [31:0] wd   [3] = '{default: '0};
    logic [3:0]  st   [3] = '{default: '0};
    logic [31:0] prd  [3];

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_regfile_slave #(
            .ADDR_WIDTH (8),
            .DATA_WIDTH (32),
            .NUM_REGS   (16),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .RO_MASK    (RO)
        ) u_dut (
            .pclk        (clk),
            .presetn     (presetn),
            .paddr       (addr[g]),
            .pselx       (psel[g]),
            .penable     (pen[g]),
            .pwrite      (pwr[g]),
            .pwdata      (wd[g]),
            .pstrb       (st[g]),
            .pready      (rdy[g]),
            .prdata      (prd[g]),
            .pslave_error(perr[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          ws [3] = '{0, 2, 3};
    bit          m_setup [3];
    int          m_acc   [3];
    logic [31:0] m_regs  [3][16];

    function automatic void model_out(input int i, output bit e_rdy, output bit e_err,
                                      output logic [31:0] e_rd);
        int  idx;
        bit  viol;
        bit  bad;
        idx   = int'(addr[i]) / 4;
        viol  = psel[i] && pen[i] && !m_setup[i];
        e_rdy = presetn && psel[i] && pen[i] && (viol || m_acc[i] == ws[i]);
        bad   = (addr[i] % 4 != 0) || (idx >= 16) || (pwr[i] && idx < 16 && RO[idx]) || viol;
        e_err = e_rdy && bad;
        e_rd  = (e_rdy && !bad) ? m_regs[i][idx] : 32'h0;
    endfunction

    always @(negedge presetn) begin
        for (int i = 0; i < 3; i++) begin
            m_setup[i] = 1'b0;
            m_acc[i]   = 0;
            for (int r = 0; r < 16; r++) m_regs[i][r] = 32'h0;
        end
    end

    always @(posedge clk) begin
        bit          e_rdy, e_err;
        logic [31:0] e_rd;
        if (presetn) begin
            for (int i = 0; i < 3; i++) begin
                model_out(i, e_rdy, e_err, e_rd);
                if (psel[i] && !pen[i]) begin
                    m_setup[i] = 1'b1;
                    m_acc[i]   = 0;
                end else if (e_rdy) begin
                    if (pwr[i] && !e_err)
                        for (int k = 0; k < 4; k++)
                            if (st[i][k]) m_regs[i][addr[i]/4][k*8 +: 8] = wd[i][k*8 +: 8];
                    m_setup[i] = 1'b0;
                    m_acc[i]   = 0;
                end else if (!psel[i]) begin
                    m_setup[i] = 1'b0;
                    m_acc[i]   = 0;
                end else begin
                    m_acc[i]++;
                end
            end
        end
    end

    // The compare process checks every instance on every falling edge.
    always @(negedge clk) begin
        bit          e_rdy, e_err;
        logic [31:0] e_rd;
        for (int i = 0; i < 3; i++) begin
            model_out(i, e_rdy, e_err, e_rd);
            chk($sformatf("u%0d pready", i), 32'(rdy[i]), 32'(e_rdy));
            chk($sformatf("u%0d pslave_error", i), 32'(perr[i]), 32'(e_err));
            chk($sformatf("u%0d prdata", i), prd[i], e_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output bit er,
                        output int cyc);
        bit done = 0;
        rd = '0; er = 0;
        @(posedge clk); #1;
        psel[i] = 1'b1; pen[i] = 1'b0; pwr[i] = wr; addr[i] = a; wd[i] = d; st[i] = s;
        @(posedge clk); #1;
        pen[i] = 1'b1;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rdy[i]) begin
                done = 1; rd = prd[i]; er = perr[i];
            end
            @(posedge clk); #1;
        end
        chk($sformatf("u%0d transfer completes", i), 32'(done), 32'd1);
        psel[i] = 1'b0; pen[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          cyc;

        #1 presetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset pready", 32'(rdy), 32'd0);
        presetn = 1'b1;

        // Zero-wait write, then read back.
        xfer(0, 1, 8'h04, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        chk("ws0 write cycles", 32'(cyc), 32'd1);
        chk("ws0 write err", 32'(er), 32'd0);
        xfer(0, 0, 8'h04, 32'h0, 4'h0, rd, er, cyc);
        chk("ws0 read data", rd, 32'hDEADBEEF);
        chk("ws0 read cycles", 32'(cyc), 32'd1);

        // Byte strobes, and an all-zero strobe as a no-op.
        xfer(0, 1, 8'h08, 32'h11223344, 4'hF, rd, er, cyc);
        xfer(0, 1, 8'h08, 32'hAABBCCDD, 4'h5, rd, er, cyc);
        xfer(0, 0, 8'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("strobe merge", rd, 32'h11BB33DD);
        xfer(0, 1, 8'h08, 32'hFFFFFFFF, 4'h0, rd, er, cyc);
        chk("zero strobe err", 32'(er), 32'd0);
        xfer(0, 0, 8'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("zero strobe no-op", rd, 32'h11BB33DD);

        // Decode errors.
        xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, er, cyc);
        chk("out of range err", 32'(er), 32'd1);
        chk("out of range data", rd, 32'h0);
        xfer(0, 1, 8'h02, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
        chk("misaligned err", 32'(er), 32'd1);
        xfer(0, 0, 8'h00, 32'h0, 4'h0, rd, er, cyc);
        chk("misaligned no write", rd, 32'h0);
        xfer(0, 1, 8'h14, 32'h12345678, 4'hF, rd, er, cyc);
        chk("read-only write err", 32'(er), 32'd1);
        xfer(0, 0, 8'h14, 32'h0, 4'h0, rd, er, cyc);
        chk("read-only value", rd, 32'h0);
        chk("read-only read err", 32'(er), 32'd0);

        // Protocol violation with no setup on the WAIT_STATES=2 instance.
        @(posedge clk); #1;
        psel[1] = 1'b1; pen[1] = 1'b1; pwr[1] = 1'b0; addr[1] = 8'h04;
        @(negedge clk);
        chk("violation pready", 32'(rdy[1]), 32'd1);
        chk("violation err", 32'(perr[1]), 32'd1);
        @(posedge clk); #1;
        psel[1] = 1'b0; pen[1] = 1'b0;
        @(negedge clk);
        chk("violation one cycle", 32'(rdy[1]), 32'd0);

        // Wait states on the WAIT_STATES=3 instance.
        xfer(2, 1, 8'h0C, 32'h12345678, 4'hF, rd, er, cyc);
        chk("ws3 write cycles", 32'(cyc), 32'd4);
        xfer(2, 0, 8'h0C, 32'h0, 4'h0, rd, er, cyc);
        chk("ws3 read data", rd, 32'h12345678);
        chk("ws3 read cycles", 32'(cyc), 32'd4);

        // Abort in the middle of the wait states.
        @(posedge clk); #1;
        psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1; addr[2] = 8'h0C;
        wd[2] = 32'hCAFEF00D; st[2] = 4'hF;
        @(posedge clk); #1;
        pen[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        psel[2] = 1'b0; pen[2] = 1'b0;
        xfer(2, 0, 8'h0C, 32'h0, 4'h0, rd, er, cyc);
        chk("abort no write", rd, 32'h12345678);
        chk("after abort cycles", 32'(cyc), 32'd4);

        // Reset in the middle of an access on the WAIT_STATES=2 instance.
        @(posedge clk); #1;
        psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; addr[1] = 8'h10;
        wd[1] = 32'h00000055; st[1] = 4'hF;
        @(posedge clk); #1;
        pen[1] = 1'b1;
        @(negedge clk); #1;
        presetn = 1'b0;
        #1;
        chk("mid reset pready", 32'(rdy[1]), 32'd0);
        chk("mid reset prdata", prd[1], 32'h0);
        chk("mid reset err", 32'(perr[1]), 32'd0);
        @(posedge clk); #1;
        psel[1] = 1'b0; pen[1] = 1'b0;
        @(posedge clk); #1;
        presetn = 1'b1;
        xfer(1, 0, 8'h10, 32'h0, 4'h0, rd, er, cyc);
        chk("post reset u1 reg4", rd, 32'h0);
        chk("post reset u1 cycles", 32'(cyc), 32'd3);
        xfer(0, 0, 8'h04, 32'h0, 4'h0, rd, er, cyc);
        chk("post reset u0 reg1", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB slave holding a register file of NUM_REGS words of DATA_WIDTH bits. It is the successor to the fixed 2-bit APB interface: address and data width are generic, and it adds programmable wait states, byte write strobes, read-only registers, and error reporting for decode and protocol violations. It sits behind the APB bridge as a leaf peripheral and serves as the DUT for the APB UVM environment.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of paddr; must be at least log2(NUM_REGS)+log2(DATA_WIDTH/8).
- DATA_WIDTH, 32, data width; must be 8, 16 or 32.
- NUM_REGS, 16, number of registers; from 1 to 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0, cycles pready is held low in the access phase; from 0 to 15.
- RO_MASK, 0, a NUM_REGS-bit mask; bit i=1 makes register i read-only.

Ports:
- pclk, input, 1, clock; all state changes on the rising edge.
- presetn, input, 1, asynchronous active-low reset.
- paddr, input, ADDR_WIDTH, byte address.
- pselx, input, 1, slave select.
- penable, input, 1, access-phase indicator.
- pwrite, input, 1, 1=write, 0=read.
- pwdata, input, DATA_WIDTH, write data.
- pstrb, input, DATA_WIDTH/8, byte write enables.
- pready, output, 1, transfer completes in this cycle.
- prdata, output, DATA_WIDTH, read data; valid only when pready=1, else 0.
- pslave_error, output, 1, error flag; valid only when pready=1, else 0.

## Operation
- Internal state: the regs array (NUM_REGS x DATA_WIDTH), an armed flag, and a wait counter wcnt (4 bits).
- Setup detection: on a rising edge where pselx=1 and penable=0, set armed=1 and clear wcnt.
- Access phase: the current cycle is an access when pselx=1, penable=1 and armed=1.
- Wait states: on each edge during an access with wcnt<WAIT_STATES, increment wcnt.
- pready (combinational):
  - 1 during an access with wcnt==WAIT_STATES.
  - 1 when pselx=1, penable=1 and armed=0 (protocol violation).
  - 0 otherwise.
- Completion: a cycle with pselx=1, penable=1 and pready=1. On the completion edge, clear armed and wcnt.
- Decode:
  - idx = paddr >> log2(DATA_WIDTH/8).
  - Misaligned means the low log2(DATA_WIDTH/8) address bits are non-zero.
  - err = misaligned, or idx>=NUM_REGS, or (pwrite and RO_MASK[idx]), or protocol violation.
- Write: on the completion edge, if err=0, write each byte lane k with pstrb[k]=1 into regs[idx]. pstrb all-zero is a legal no-op with no error.
- Read: during the completion cycle, prdata=regs[idx] if err=0, else 0. pstrb is ignored on reads.
- pslave_error = pready & err. An erroring transfer never modifies regs.
- Abort: if pselx falls before completion, clear armed and wcnt on the next edge. No write occurs.

## Timing
- Reset values: regs=0, armed=0, wcnt=0. pready=0, prdata=0 and pslave_error=0 whenever pselx=0 or presetn=0.
- Reset takes effect asynchronously and can hit mid-transfer. A transfer in flight is dropped; the master sees pready=0 until a fresh setup phase.
- Transfer length with WAIT_STATES=N: setup cycle + (N+1) access cycles, so pready rises N cycles after penable.
- Write data is visible to a read on the next transfer; back-to-back setup after completion is supported.
- A setup phase may directly follow the completion cycle (pselx held high, penable low). armed is set again on that edge.
- Protocol violation with no prior setup completes in one cycle regardless of WAIT_STATES.
- Outputs are combinational from armed, wcnt, regs and the APB inputs; there are no output registers.

## Test plan
- Reset and idle: assert presetn=0 mid-access with WAIT_STATES=2 -> pready, prdata and pslave_error are 0 immediately; after release, reading any register returns 0.
- Zero-wait write then read: DATA_WIDTH=32, write 0xDEADBEEF to paddr 0x04 with pstrb=0xF, then read 0x04 -> pready=1 in the first access cycle, prdata=0xDEADBEEF, pslave_error=0.
- Byte strobes: reg 2 holds 0x11223344; write 0xAABBCCDD with pstrb=0x5 -> reg 2 reads 0x11BB33DD.
- Wait states: WAIT_STATES=3 -> pready=0 for 3 access cycles and 1 on the 4th; the write commits only on the 4th edge.
- Errors:
  - Read paddr 0x40 with NUM_REGS=16 -> pslave_error=1, prdata=0.
  - Write paddr 0x02 (misaligned) -> pslave_error=1, regs unchanged.
  - Write a register with RO_MASK bit set -> pslave_error=1, value unchanged.
- Protocol and abort:
  - pselx=1, penable=1 with no setup -> one-cycle pready=1 with pslave_error=1.
  - Drop pselx mid-wait -> no write occurs, and the next transfer behaves normally.
